// File: rtl/ram_bist_ctrl.sv
// Write/read-back self-test sequencer for a single-port RAM.
// Fills every word with (2*addr + seed), reads each back, and records mismatches.
module ram_bist_ctrl #(
  parameter int unsigned AW    = 10,
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 1024
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] seed,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic          ram_cs,
  output logic          ram_rd,
  output logic          ram_wr,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [AW:0]   err_count,
  output logic [AW-1:0] first_fail_addr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_RD_ADDR,
    S_RD_CMP,
    S_DONE
  } state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] seed_q, seed_d;
  logic [AW:0]   err_q, err_d;
  logic [AW-1:0] ffa_q, ffa_d;
  logic          pass_q, pass_d;
  logic [DW-1:0] exp_data;

  // Expected word for the current address; the shifted address is truncated to DW.
  assign exp_data = DW'({addr_q, 1'b0}) + seed_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      seed_q  <= '0;
      err_q   <= '0;
      ffa_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      seed_q  <= seed_d;
      err_q   <= err_d;
      ffa_q   <= ffa_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    seed_d  = seed_q;
    err_d   = err_q;
    ffa_d   = ffa_q;
    pass_d  = pass_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_WRITE;
          seed_d  = seed;
          addr_d  = '0;
          err_d   = '0;
          ffa_d   = '0;
          pass_d  = 1'b0;
        end
      end
      S_WRITE: begin
        if (addr_q == LAST_ADDR) begin
          addr_d  = '0;
          state_d = S_RD_ADDR;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      S_RD_ADDR: state_d = S_RD_CMP;
      S_RD_CMP: begin
        if (ram_rdata != exp_data) begin
          err_d = err_q + 1'b1;
          if (err_q == '0) ffa_d = addr_q;
        end
        // pass reflects the count including this final compare
        if (addr_q == LAST_ADDR) begin
          state_d = S_DONE;
          pass_d  = (err_d == '0);
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = S_RD_ADDR;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ram_addr        = addr_q;
  assign ram_wr          = (state_q == S_WRITE);
  assign ram_rd          = (state_q == S_RD_ADDR) || (state_q == S_RD_CMP);
  assign ram_cs          = ram_wr || ram_rd;
  assign ram_wdata       = ram_wr ? exp_data : '0;
  assign busy            = ram_cs;
  assign done            = (state_q == S_DONE);
  assign pass            = pass_q;
  assign err_count       = err_q;
  assign first_fail_addr = ffa_q;

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Directed bench for ram_bist_ctrl with a behavioural 1024x8 RAM and read fault injection.
module tb_ram_bist_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] seed;
  logic [9:0] ram_addr;
  logic [7:0] ram_wdata;
  logic [7:0] ram_rdata;
  logic       ram_cs, ram_rd, ram_wr;
  logic       busy, done, pass;
  logic [10:0] err_count;
  logic [9:0] first_fail_addr;

  int errors = 0;
  int checks = 0;
  int fault_a = -1;
  int fault_b = -1;
  int cyc;
  logic [7:0] mem [0:1023];

  ram_bist_ctrl #(.AW(10), .DW(8), .DEPTH(1024)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .seed(seed),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .ram_cs(ram_cs), .ram_rd(ram_rd), .ram_wr(ram_wr),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_fail_addr(first_fail_addr)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM model; selected addresses return bit 0 inverted.
  always @(posedge clk) begin
    if (ram_cs && ram_wr) mem[ram_addr] <= ram_wdata;
    if (ram_cs && ram_rd)
      ram_rdata <= mem[ram_addr] ^ ((int'(ram_addr) == fault_a || int'(ram_addr) == fault_b) ? 8'h01 : 8'h00);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    check("strobe_overlap", {31'd0, ram_rd && ram_wr}, 32'd0);
    if (!busy) check("idle_strobes", {29'd0, ram_cs, ram_rd, ram_wr}, 32'd0);
  end

  task automatic do_start(input logic [7:0] s);
    start = 1'b1;
    seed  = s;
    @(posedge clk); #1;
    start = 1'b0;
    seed  = 8'hEE;
  endtask

  // Counts edges after E0 until done; optional ignored start pulses at given cycles.
  task automatic wait_done(input int pa, input int pb, output int n);
    n = 0;
    while (!done && n < 4000) begin
      start = (n == pa - 1 || n == pb - 1);
      seed  = 8'hAA;
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    if (!done) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_pass"}, {31'd0, pass}, 32'd0);
    check({tag, "_cs"},   {31'd0, ram_cs}, 32'd0);
    check({tag, "_addr"}, {22'd0, ram_addr}, 32'd0);
    check({tag, "_wdata"}, {24'd0, ram_wdata}, 32'd0);
    check({tag, "_err"},  {21'd0, err_count}, 32'd0);
    check({tag, "_ffa"},  {22'd0, first_fail_addr}, 32'd0);
  endtask

  task automatic check_result(input string tag, input int e, input int fa, input int p);
    check({tag, "_cycles"}, cyc, 32'd3072);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_err"},  {21'd0, err_count}, e);
    check({tag, "_ffa"},  {22'd0, first_fail_addr}, fa);
    check({tag, "_pass"}, {31'd0, pass}, p);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b1; seed = 8'h12;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("rst_with_start");
    start = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_reset_vals("idle");

    // Seed 0, clean RAM
    do_start(8'h00);
    check("s0_busy_e0", {31'd0, busy}, 32'd1);
    check("s0_wr_e0", {29'd0, ram_cs, ram_rd, ram_wr}, 32'd5);
    wait_done(-10, -10, cyc);
    check_result("s0", 0, 0, 1);
    check("s0_mem200", {24'd0, mem[200]}, 32'd144);
    check("s0_mem1023", {24'd0, mem[1023]}, 32'd254);

    // Seed 0x55
    do_start(8'h55);
    check("s55_wdata_e0", {24'd0, ram_wdata}, 32'h55);
    check("s55_done_cleared", {31'd0, done}, 32'd0);
    wait_done(-10, -10, cyc);
    check_result("s55", 0, 0, 1);
    check("s55_mem0", {24'd0, mem[0]}, 32'h55);
    check("s55_mem128", {24'd0, mem[128]}, 32'h55);
    check("s55_mem1023", {24'd0, mem[1023]}, 32'h53);

    // Two read faults
    fault_a = 5; fault_b = 900;
    do_start(8'h07);
    wait_done(-10, -10, cyc);
    check_result("flt2", 2, 5, 0);

    // Fault on the last compare only
    fault_a = 1023; fault_b = -1;
    do_start(8'h07);
    wait_done(-10, -10, cyc);
    check_result("flt_last", 1, 1023, 0);
    fault_a = -1;

    // start pulses while busy are ignored
    do_start(8'h3C);
    wait_done(10, 2000, cyc);
    check_result("ign", 0, 0, 1);
    check("ign_mem1", {24'd0, mem[1]}, 32'h3E);

    // Reset mid-test
    do_start(8'h11);
    wait_done(-10, -10, cyc);
    check_result("pre_abort", 0, 0, 1);
    do_start(8'h11);
    repeat (499) begin @(posedge clk); #1; end
    check("abort_busy_before", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_reset_vals("abort");
    repeat (5) begin @(posedge clk); #1; end
    check("abort_stays_idle", {31'd0, busy}, 32'd0);
    do_start(8'h22);
    wait_done(-10, -10, cyc);
    check_result("after_abort", 0, 0, 1);

    // Back-to-back restart the cycle after done
    @(posedge clk); #1;
    do_start(8'h90);
    check("b2b_done_drop", {31'd0, done}, 32'd0);
    check("b2b_busy", {31'd0, busy}, 32'd1);
    wait_done(-10, -10, cyc);
    check_result("b2b", 0, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
